// File: rtl/cellrv32_clkgen_pkg.sv
// Shared constants for the IO prescaler tick generator: counter width,
// tap map and symbolic ratio selects used by the peripherals.
package cellrv32_clkgen_pkg;

  localparam int clkgen_width_c = 12;
  localparam int clkgen_num_c   = 8;

  // Counter bit feeding each tick output; entry i drives clkgen_o[i].
  localparam logic [clkgen_num_c-1:0][3:0] clkgen_tap_c = {
    4'd11, 4'd10, 4'd9, 4'd6, 4'd5, 4'd2, 4'd1, 4'd0
  };

  typedef enum logic [2:0] {
    clk_div2_c    = 3'd0,
    clk_div4_c    = 3'd1,
    clk_div8_c    = 3'd2,
    clk_div64_c   = 3'd3,
    clk_div128_c  = 3'd4,
    clk_div1024_c = 3'd5,
    clk_div2048_c = 3'd6,
    clk_div4096_c = 3'd7
  } clk_div_e;

endpackage

// File: rtl/cellrv32_clkgen_if.sv
// Request/tick bundle between the peripherals (master) and the prescaler (slave).
interface cellrv32_clkgen_if
  import cellrv32_clkgen_pkg::*;
#(
  parameter int NUM_REQ = 8
);

  logic [NUM_REQ-1:0]      clkgen_en_i;
  logic                    freeze_i;
  logic [clkgen_num_c-1:0] clkgen_o;
  logic                    active_o;

  modport master (
    output clkgen_en_i,
    output freeze_i,
    input  clkgen_o,
    input  active_o
  );

  modport slave (
    input  clkgen_en_i,
    input  freeze_i,
    output clkgen_o,
    output active_o
  );

endinterface

// File: rtl/cellrv32_clkgen.sv
// Shared prescaler: free-running counter while any peripheral requests it,
// with rising-edge detection on fixed counter taps to form one-cycle ticks.
module cellrv32_clkgen
  import cellrv32_clkgen_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = clkgen_width_c
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  cellrv32_clkgen_if.slave  bus
);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [clkgen_num_c-1:0] tap_prev_q, tap_prev_d;
  logic [clkgen_num_c-1:0] clkgen_q, clkgen_d;
  logic                    active_q, active_d;
  logic [clkgen_num_c-1:0] tap_cur_s;
  logic [clkgen_num_c-1:0] tick_s;
  logic                    en_any_s;

  // Any enabled requester keeps the prescaler running.
  always_comb begin
    en_any_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      en_any_s = en_any_s | bus.clkgen_en_i[i];
    end
  end

  // Only the tapped bits of the previous count matter, so only those are kept.
  for (genvar g = 0; g < clkgen_num_c; g++) begin : g_tap
    assign tap_cur_s[g] = cnt_q[clkgen_tap_c[g]];
    assign tick_s[g]    = tap_cur_s[g] & ~tap_prev_q[g];
  end

  // Next-state: idle clears phase, freeze holds counter and history.
  always_comb begin
    cnt_d      = cnt_q;
    tap_prev_d = tap_prev_q;
    clkgen_d   = {clkgen_num_c{1'b0}};
    active_d   = 1'b0;
    if (!en_any_s) begin
      cnt_d      = {CNT_W{1'b0}};
      tap_prev_d = {clkgen_num_c{1'b0}};
    end else if (bus.freeze_i) begin
      cnt_d      = cnt_q;
      tap_prev_d = tap_prev_q;
    end else begin
      cnt_d      = cnt_q + CNT_W'(1);
      tap_prev_d = tap_cur_s;
      clkgen_d   = tick_s;
      active_d   = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q      <= {CNT_W{1'b0}};
      tap_prev_q <= {clkgen_num_c{1'b0}};
      clkgen_q   <= {clkgen_num_c{1'b0}};
      active_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tap_prev_q <= tap_prev_d;
      clkgen_q   <= clkgen_d;
      active_q   <= active_d;
    end
  end

  assign bus.clkgen_o = clkgen_q;
  assign bus.active_o = active_q;

endmodule

// File: tb/tb_cellrv32_clkgen.sv
// Directed bench for cellrv32_clkgen: reset/idle, ratios, latency, wrap,
// freeze, request handover, idle restart and reset during activity.
module tb_cellrv32_clkgen;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  cellrv32_clkgen_if #(.NUM_REQ(8)) bif ();

  cellrv32_clkgen #(.NUM_REQ(8), .CNT_W(12)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam int N = 14400;
    int          exp_cnt [8] = '{4096, 2048, 1024, 128, 64, 8, 4, 2};
    int          tcnt    [8];
    int          first   [8];
    int          wide;
    int          bad;
    int          last7, n7, gap7_bad;
    int          last0, min0, max0;
    int          found, pos, ntick;
    logic [7:0]  cg, prev_cg;
    logic        prev0;

    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    bif.clkgen_en_i = 8'h00;
    bif.freeze_i    = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_clkgen", 32'(bif.clkgen_o), 32'd0);
    chk("rst_active", 32'(bif.active_o), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    rstn = 1'b1;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (bif.clkgen_o !== 8'h00 || bif.active_o !== 1'b0 || dut.cnt_q !== 12'd0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Ratios, first-tick latency, wrap spacing
    for (int b = 0; b < 8; b++) begin
      tcnt[b]  = 0;
      first[b] = -1;
    end
    wide = 0; last7 = -1; n7 = 0; gap7_bad = 0;
    last0 = -1; min0 = 1000; max0 = 0;
    prev_cg = 8'h00;
    bif.clkgen_en_i = 8'h01;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      cg = bif.clkgen_o;
      for (int b = 0; b < 8; b++) begin
        if (cg[b]) begin
          if (j < 8192) tcnt[b]++;
          if (first[b] < 0) first[b] = j;
          if (prev_cg[b]) wide++;
        end
      end
      if (cg[7]) begin
        if (last7 >= 0 && (j - last7) != 4096) gap7_bad++;
        last7 = j;
        n7++;
      end
      if (cg[0]) begin
        if (last0 >= 0) begin
          if ((j - last0) < min0) min0 = j - last0;
          if ((j - last0) > max0) max0 = j - last0;
        end
        last0 = j;
      end
      prev_cg = cg;
    end
    for (int b = 0; b < 8; b++) chk($sformatf("ratio_cnt%0d", b), 32'(tcnt[b]), 32'(exp_cnt[b]));
    chk("pulse_width", 32'(wide), 32'd0);
    chk("first_div2", 32'(first[0]), 32'd1);
    chk("first_div8", 32'(first[2]), 32'd4);
    chk("first_div4096", 32'(first[7]), 32'd2048);
    chk("div4096_n", 32'(n7), 32'd4);
    chk("div4096_gap", 32'(gap7_bad), 32'd0);
    chk("div2_min_gap", 32'(min0), 32'd2);
    chk("div2_max_gap", 32'(max0), 32'd2);

    // Freeze for 10 cycles two cycles after a /8 tick
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bif.clkgen_o[2]) found = 1;
    end
    chk("frz_sync", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    bif.freeze_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.clkgen_o !== 8'h00 || bif.active_o !== 1'b0) bad++;
    end
    bif.freeze_i = 1'b0;
    chk("frz_quiet", 32'(bad), 32'd0);
    pos = -1; ntick = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("frz_active_back", 32'(bif.active_o), 32'd1);
      if (bif.clkgen_o[2]) begin
        ntick++;
        pos = k;
      end
    end
    chk("frz_div8_ticks", 32'(ntick), 32'd1);
    chk("frz_div8_pos", 32'(pos), 32'd6);

    // Request handover keeps phase
    bad = 0; found = 0;
    prev0 = bif.clkgen_o[0];
    for (int j = 0; j < 40; j++) begin
      case (j)
        0:       bif.clkgen_en_i = 8'h09;
        10:      bif.clkgen_en_i = 8'h08;
        20:      bif.clkgen_en_i = 8'h09;
        30:      bif.clkgen_en_i = 8'h01;
        default: bif.clkgen_en_i = bif.clkgen_en_i;
      endcase
      @(negedge clk);
      if (bif.clkgen_o[0] === prev0) bad++;
      if (bif.active_o !== 1'b1) found++;
      prev0 = bif.clkgen_o[0];
    end
    chk("handover_div2", 32'(bad), 32'd0);
    chk("handover_active", 32'(found), 32'd0);

    // One idle cycle restarts phase
    bif.clkgen_en_i = 8'h00;
    @(negedge clk);
    chk("idle1_cnt", 32'(dut.cnt_q), 32'd0);
    chk("idle1_clkgen", 32'(bif.clkgen_o), 32'd0);
    chk("idle1_active", 32'(bif.active_o), 32'd0);
    bif.clkgen_en_i = 8'h01;
    first[0] = -1; first[2] = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bif.clkgen_o[0] && first[0] < 0) first[0] = j;
      if (bif.clkgen_o[2] && first[2] < 0) first[2] = j;
    end
    chk("restart_div2", 32'(first[0]), 32'd1);
    chk("restart_div8", 32'(first[2]), 32'd4);

    // Reset on an edge that would otherwise produce a /2 tick
    @(negedge clk);
    chk("pre_rst_active", 32'(bif.active_o), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_clkgen", 32'(bif.clkgen_o), 32'd0);
    chk("midrst_active", 32'(bif.active_o), 32'd0);
    chk("midrst_cnt", 32'(dut.cnt_q), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
